// File: rtl/conv1_rm_pkg.sv
// conv1_rm_pkg: shared constants, FSM states and FIFO entry type for the conv1 row-major SRAM read path
package conv1_rm_pkg;
   localparam int CONV1_RM_DATA_WIDTH = 16;
   localparam int CONV1_RM_ADDR_WIDTH = 9;
   localparam int CONV1_RM_WORDS = 336;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;
   typedef struct packed {
      logic [CONV1_RM_DATA_WIDTH-1:0] data;
      logic last;
   } rd_fifo_ent_t;
endpackage

// File: rtl/conv1_rm_rd_fifo.sv
// conv1_rm_rd_fifo: small synchronous FIFO with occupancy count and head read straight from storage
module conv1_rm_rd_fifo
   import conv1_rm_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk0,
   input  logic                          rst0_n,
   input  logic                          push,
   input  rd_fifo_ent_t                  wdata,
   input  logic                          pop,
   output rd_fifo_ent_t                  head,
   output logic [$clog2(FIFO_DEPTH):0]   count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   rd_fifo_ent_t mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end
   assign head = mem[rd_ptr];
endmodule

// File: rtl/conv1_rm_sram_rd_streamer.sv
// conv1_rm_sram_rd_streamer: windowed SRAM port-0 reader feeding a credit-checked valid/ready stream.
// Define CONV1_RD_CHKSUM_EN to add the chksum output (running sum of popped words).
module conv1_rm_sram_rd_streamer
   import conv1_rm_pkg::*;
#(
   parameter int DATA_WIDTH = CONV1_RM_DATA_WIDTH,
   parameter int ADDR_WIDTH = CONV1_RM_ADDR_WIDTH,
   parameter int WORDS      = CONV1_RM_WORDS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk0,
   input  logic                  rst0_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] length,
   output logic                  busy,
   output logic                  done,
   output logic                  cmd_err,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
`ifdef CONV1_RD_CHKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] chksum
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0] WORDS_V = (ADDR_WIDTH+1)'(WORDS);
   rd_state_t state, state_nx;
   logic [ADDR_WIDTH-1:0] nxt, rem, addr_q;
   logic [CW-1:0] count;
   logic inflight, inflight_last, issue, pop, accept, drain_done;
   rd_fifo_ent_t head;
   assign pop = m_valid & m_ready;
   assign m_valid = count != '0;
   assign m_data = head.data;
   assign m_last = m_valid & head.last;
   assign busy = state != IDLE;
   assign accept = state == IDLE && start && length != '0 &&
                   ({1'b0, base_addr} + {1'b0, length}) <= WORDS_V;
   // A read is only launched if its word is guaranteed a FIFO slot when it lands.
   assign issue = state == RUN &&
                  ({1'b0, count} + {{CW{1'b0}}, inflight} < DEPTH_V + {{CW{1'b0}}, pop});
   assign drain_done = state == DRAIN && count == '0 && !inflight;
   assign sram_csb0 = !issue;
   assign sram_web0 = 1'b1;
   assign sram_addr0 = issue ? nxt : addr_q;
   always_comb begin
      state_nx = state;
      if (accept) state_nx = RUN;
      else if (issue && rem == ADDR_WIDTH'(1)) state_nx = DRAIN;
      else if (drain_done) state_nx = IDLE;
   end
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         state <= IDLE;
         nxt <= '0;
         rem <= '0;
         addr_q <= '0;
         inflight <= 1'b0;
         inflight_last <= 1'b0;
         done <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         state <= state_nx;
         done <= drain_done;
         cmd_err <= state == IDLE && start && !accept;
         inflight <= issue;
         inflight_last <= issue && rem == ADDR_WIDTH'(1);
         if (accept) begin
            nxt <= base_addr;
            rem <= length;
         end else if (issue) begin
            nxt <= nxt + 1'b1;
            rem <= rem - 1'b1;
            addr_q <= nxt;
         end
      end
   end
   // Data of the read registered last edge is valid now and captured on this edge.
   conv1_rm_rd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk0   (clk0),
      .rst0_n (rst0_n),
      .push   (inflight),
      .wdata  ({sram_dout0, inflight_last}),
      .pop    (pop),
      .head   (head),
      .count  (count)
   );
`ifdef CONV1_RD_CHKSUM_EN
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) chksum <= '0;
      else if (accept) chksum <= '0;
      else if (pop) chksum <= chksum + m_data;
   end
`endif
endmodule

// File: tb/tb_conv1_rm_sram_rd_streamer.sv
// tb_conv1_rm_sram_rd_streamer: scoreboard bench with a cycle-accurate model of the conv1 SRAM read port
module tb_conv1_rm_sram_rd_streamer;
   logic clk0 = 1'b0;
   logic rst0_n, start, busy, done, cmd_err, sram_csb0, sram_web0, m_valid, m_ready, m_last;
   logic [8:0] base_addr, length, sram_addr0;
   logic [15:0] sram_dout0, m_data;
`ifdef CONV1_RD_CHKSUM_EN
   logic [15:0] chksum;
`endif
   logic [15:0] mem [336];
   logic q_csb = 1'b1;
   logic [8:0] q_addr = '0;
   logic [16:0] sb [$];
   int n_checks = 0, n_errors = 0;
   int cyc = 0, s_cyc = 0, done_cyc = 0, last_pop_cyc = 0, reads = 0, out_cnt = 0, r0 = 0;
   conv1_rm_sram_rd_streamer dut (
      .clk0       (clk0),
      .rst0_n     (rst0_n),
      .start      (start),
      .base_addr  (base_addr),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .cmd_err    (cmd_err),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_addr0 (sram_addr0),
      .sram_dout0 (sram_dout0),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last)
`ifdef CONV1_RD_CHKSUM_EN
      ,
      .chksum     (chksum)
`endif
   );
   always #5 clk0 = ~clk0;
   always @(posedge clk0) cyc <= cyc + 1;
   // SRAM macro: registers csb/addr at posedge, data after negedge, X shortly after next posedge
   always @(posedge clk0) begin
      q_csb <= sram_csb0;
      q_addr <= sram_addr0;
   end
   initial begin
      for (int a = 0; a < 336; a++) mem[a] = 16'(a * 3);
      sram_dout0 = 'x;
      forever begin
         @(negedge clk0);
         if (!q_csb && q_addr < 9'd336) sram_dout0 = mem[q_addr];
         @(posedge clk0);
         #1 sram_dout0 = 'x;
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask
   // Outputs and inputs are stable at negedge; a handshake seen here completes on the next posedge.
   always @(negedge clk0) begin
      if (!rst0_n) out_cnt = 0;
      else begin
         if (!sram_csb0) begin
            check("credit", 32'((out_cnt - int'(m_valid && m_ready)) < 4), 1);
            reads++;
            out_cnt++;
         end
         if (m_valid && m_ready) begin
            if (sb.size() == 0) check("extra_word", {16'd0, m_data}, 32'hffff_ffff);
            else begin
               logic [16:0] e;
               e = sb.pop_front();
               check("m_data", m_data, e[15:0]);
               check("m_last", m_last, e[16]);
            end
            last_pop_cyc = cyc + 1;
            out_cnt--;
         end
      end
   end
   task automatic tick();
      @(posedge clk0);
      #1;
   endtask
   task automatic cmd(input int b, input int l, input bit exp_ok);
      base_addr = 9'(b);
      length = 9'(l);
      start = 1'b1;
      if (exp_ok) for (int i = 0; i < l; i++) sb.push_back({i == l - 1, 16'((b + i) * 3)});
      tick();
      start = 1'b0;
      s_cyc = cyc;
   endtask
   task automatic wait_done(input int bound);
      int n = 0;
      while (!done && n < bound) begin
         tick();
         n++;
      end
      check("done_seen", done, 1);
      done_cyc = cyc;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      rst0_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cmd_err", cmd_err, 0);
      check("rst_csb", sram_csb0, 1);
      check("rst_web", sram_web0, 1);
      check("rst_addr", sram_addr0, 0);
      check("rst_valid", m_valid, 0);
      check("rst_last", m_last, 0);
      check("rst_data", m_data, 0);
`ifdef CONV1_RD_CHKSUM_EN
      check("rst_chksum", chksum, 0);
`endif
      rst0_n = 1'b1;
      tick();
      // full-rate window
      m_ready = 1'b1;
      cmd(0, 8, 1);
      check("t1_busy", busy, 1);
      check("t1_lat0", m_valid, 0);
      tick();
      check("t1_lat1", m_valid, 0);
      tick();
      check("t1_lat2", m_valid, 1);
      check("t1_first", m_data, 0);
      wait_done(50);
      check("t1_last_pop", last_pop_cyc, s_cyc + 10);
      check("t1_done_cyc", done_cyc, last_pop_cyc + 1);
      check("t1_busy_end", busy, 0);
      check("t1_sb_empty", sb.size(), 0);
      tick();
      check("t1_done_pulse", done, 0);
      // top-of-memory window under toggling backpressure; starts while busy are ignored
      cmd(330, 6, 1);
      cmd(331, 6, 0);
      check("t2_ign_bad", cmd_err, 0);
      cmd(0, 2, 0);
      check("t2_ign_good", cmd_err, 0);
      for (int i = 0; i < 200 && !done; i++) begin
         m_ready = ~m_ready;
         tick();
      end
      check("t2_done", done, 1);
      check("t2_sb_empty", sb.size(), 0);
      m_ready = 1'b1;
      tick();
      // rejected commands
      r0 = reads;
      cmd(331, 6, 0);
      check("t3_err_a", cmd_err, 1);
      check("t3_busy_a", busy, 0);
      check("t3_csb_a", sram_csb0, 1);
      cmd(5, 0, 0);
      check("t3_err_b", cmd_err, 1);
      check("t3_busy_b", busy, 0);
      tick();
      check("t3_err_clr", cmd_err, 0);
      check("t3_no_reads", reads - r0, 0);
      // stall: only as many reads as FIFO slots
      m_ready = 1'b0;
      r0 = reads;
      cmd(100, 10, 1);
      repeat (20) tick();
      check("t4_reads", reads - r0, 4);
      check("t4_valid", m_valid, 1);
      check("t4_head", m_data, 300);
      m_ready = 1'b1;
      wait_done(60);
      check("t4_sb_empty", sb.size(), 0);
      tick();
      // reset mid-run abandons the window
      cmd(50, 20, 1);
      repeat (4) tick();
      rst0_n = 1'b0;
      #1;
      check("t5_csb", sram_csb0, 1);
      check("t5_valid", m_valid, 0);
      check("t5_busy", busy, 0);
      sb.delete();
      tick();
      rst0_n = 1'b1;
      tick();
      check("t5_valid_after", m_valid, 0);
      cmd(10, 2, 1);
      wait_done(30);
      check("t5_sb_empty", sb.size(), 0);
      tick();
`ifdef CONV1_RD_CHKSUM_EN
      cmd(0, 336, 1);
      wait_done(800);
      check("t6_chksum", chksum, 37768);
      repeat (3) tick();
      check("t6_chksum_hold", chksum, 37768);
      check("t6_sb_empty", sb.size(), 0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
